// File: rtl/transmitter_pkg.sv
// transmitter_pkg: frame header type, transmitter FSM states, frame size constants, header byte selector
package transmitter_pkg;
  typedef struct packed {
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
  } header;
  typedef enum logic [2:0] {IDLE, WAIT, HEADER, PAYLOAD, PAD} tx_state_e;
  localparam int HDR_BYTES = 14;
  localparam int MIN_PAYLOAD = 46;
  localparam int MAX_PAYLOAD = 1500;
  function automatic logic [7:0] hdr_byte(header h, logic [3:0] i);
    logic [111:0] v;
    v = h;
    v = v << {i, 3'b000};
    return v[111:104];
  endfunction
endpackage

// File: rtl/transmitter_if.sv
// transmitter_if: AXI-Stream byte link to the MAC; master drives tdata/tvalid/tlast, slave drives tready
interface transmitter_if;
  logic [7:0] tx_axis_tdata;
  logic tx_axis_tvalid;
  logic tx_axis_tlast;
  logic tx_axis_tready;
  modport master(output tx_axis_tdata, tx_axis_tvalid, tx_axis_tlast, input tx_axis_tready);
  modport slave(input tx_axis_tdata, tx_axis_tvalid, tx_axis_tlast, output tx_axis_tready);
endinterface

// File: rtl/transmitter_tx_buffer.sv
// tx_buffer: first-word-fall-through byte FIFO; ports clk, rst, i_wr_en/i_data in, i_rd_en pop, o_data head, o_count occupancy, o_full
module tx_buffer #(
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [7:0]               i_data,
  input  logic                     i_rd_en,
  output logic [7:0]               o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_wr, w_rd;
  assign w_wr = i_wr_en & ~o_full;
  assign w_rd = i_rd_en & (r_cnt != '0);
  assign o_data = r_mem[r_rp];
  assign o_count = r_cnt;
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= i_data;
endmodule

// File: rtl/transmitter.sv
// transmitter: buffers payload (btx_wr_en/tx_data/btx_full), on tx_start/tx_len/tx_header streams header+payload+pad to m_axis, flags tx_busy/tx_err
module transmitter
  import transmitter_pkg::*;
#(
  parameter int DEPTH = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btx_wr_en,
  input  logic [7:0]  tx_data,
  output logic        btx_full,
  input  logic        tx_start,
  input  logic [10:0] tx_len,
  input  header       tx_header,
  output logic        tx_busy,
  output logic        tx_err,
  transmitter_if.master m_axis
);
  tx_state_e r_state, w_next;
  header r_hdr;
  logic [10:0] r_len, r_pcnt;
  logic [3:0] r_hcnt;
  logic r_err;
  logic [7:0] w_head;
  logic [$clog2(DEPTH):0] w_count;
  logic w_hs, w_pop, w_accept;
  assign w_hs = m_axis.tx_axis_tvalid & m_axis.tx_axis_tready;
  assign w_accept = tx_start & (tx_len <= 11'(MAX_PAYLOAD));
  assign tx_err = r_err;
  tx_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk(clk),
    .rst(rst),
    .i_wr_en(btx_wr_en),
    .i_data(tx_data),
    .i_rd_en(w_pop),
    .o_data(w_head),
    .o_count(w_count),
    .o_full(btx_full)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = WAIT;
      WAIT:    if (32'(w_count) >= 32'(r_len)) w_next = HEADER;
      HEADER:  if (w_hs && r_hcnt == 4'(HDR_BYTES-1)) w_next = r_len != '0 ? PAYLOAD : PAD;
      PAYLOAD: if (w_hs && r_pcnt == r_len - 1'b1) w_next = r_len < 11'(MIN_PAYLOAD) ? PAD : IDLE;
      PAD:     if (w_hs && r_pcnt == 11'(MIN_PAYLOAD-1)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    m_axis.tx_axis_tvalid = r_state inside {HEADER, PAYLOAD, PAD};
    m_axis.tx_axis_tdata = r_state == HEADER ? hdr_byte(r_hdr, r_hcnt) : r_state == PAYLOAD ? w_head : 8'h00;
    m_axis.tx_axis_tlast = (r_state == PAYLOAD && r_pcnt == r_len - 1'b1 && r_len >= 11'(MIN_PAYLOAD)) ||
                           (r_state == PAD && r_pcnt == 11'(MIN_PAYLOAD-1));
    w_pop = r_state == PAYLOAD && m_axis.tx_axis_tready;
    tx_busy = r_state != IDLE;
  end
  // r_pcnt keeps counting through PAD so padding ends at MIN_PAYLOAD total payload bytes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_hdr <= '0;
      r_len <= '0;
      r_hcnt <= '0;
      r_pcnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= r_state == IDLE && tx_start && !w_accept;
      if (r_state == IDLE && w_accept) begin
        r_hdr <= tx_header;
        r_len <= tx_len;
        r_hcnt <= '0;
        r_pcnt <= '0;
      end
      if (w_hs && r_state == HEADER) r_hcnt <= r_hcnt + 1'b1;
      if (w_hs && r_state != HEADER) r_pcnt <= r_pcnt + 1'b1;
    end
endmodule

// File: tb/tb_transmitter.sv
// tb_transmitter: directed frames checked byte-by-byte against a queue model of the expected frame
module tb_transmitter;
  import transmitter_pkg::*;
  logic clk = 0, rst = 1, btx_wr_en = 0, tx_start = 0, rand_rdy = 0;
  logic btx_full, tx_busy, tx_err;
  logic [7:0] tx_data = 0;
  logic [10:0] tx_len = 0;
  header tx_header = '0, h1, h2;
  transmitter_if axis();
  transmitter dut (
    .clk(clk), .rst(rst), .btx_wr_en(btx_wr_en), .tx_data(tx_data), .btx_full(btx_full),
    .tx_start(tx_start), .tx_len(tx_len), .tx_header(tx_header), .tx_busy(tx_busy),
    .tx_err(tx_err), .m_axis(axis)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0, exp_len = 0, nbytes = 0;
  logic [7:0] exp_q[$], pl[$];
  logic in_frame = 0, p_stall = 0, p_l = 0;
  logic [7:0] p_d = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic build(input header h, input int len);
    logic [111:0] v = h;
    for (int i = 0; i < 14; i++) begin
      exp_q.push_back(v[111:104]);
      v = v << 8;
    end
    for (int i = 0; i < len; i++) exp_q.push_back(pl.pop_front());
    for (int i = len; i < 46; i++) exp_q.push_back(8'h00);
  endtask
  task automatic wr(input logic [7:0] b);
    btx_wr_en = 1;
    tx_data = b;
    pl.push_back(b);
    @(posedge clk); #1;
    btx_wr_en = 0;
  endtask
  task automatic start(input header h, input int len);
    tx_start = 1;
    tx_len = 11'(len);
    tx_header = h;
    @(posedge clk); #1;
    tx_start = 0;
  endtask
  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("frame_done", 32'(exp_q.size()) + 32'(in_frame), 0);
  endtask
  always @(posedge clk) begin
    #1;
    if (rand_rdy) axis.tx_axis_tready = 1'($urandom_range(0, 1));
  end
  always @(negedge clk)
    if (!rst) begin
      if (p_stall) begin
        chk("stall_valid", axis.tx_axis_tvalid, 1);
        chk("stall_data", axis.tx_axis_tdata, p_d);
        chk("stall_last", axis.tx_axis_tlast, p_l);
      end
      if (in_frame) chk("no_bubble", axis.tx_axis_tvalid, 1);
      if (axis.tx_axis_tvalid) begin
        chk("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("tdata", axis.tx_axis_tdata, exp_q[0]);
          chk("tlast", axis.tx_axis_tlast, exp_q.size() == 1);
        end
        in_frame = 1;
        if (axis.tx_axis_tready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          nbytes++;
          if (axis.tx_axis_tlast) begin
            chk("frame_len", nbytes, exp_len);
            in_frame = 0;
            nbytes = 0;
          end
        end
      end
      p_stall = axis.tx_axis_tvalid && !axis.tx_axis_tready;
      p_d = axis.tx_axis_tdata;
      p_l = axis.tx_axis_tlast;
    end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    h1 = '{dest_mac: 48'h0A0B0C0D0E0F, src_mac: 48'h112233445566, eth_type: 16'h0800};
    h2 = '{dest_mac: 48'hFFFFFFFFFFFF, src_mac: 48'h020000000001, eth_type: 16'h86DD};
    axis.tx_axis_tready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", axis.tx_axis_tvalid, 0);
    chk("rst_tlast", axis.tx_axis_tlast, 0);
    chk("rst_tdata", axis.tx_axis_tdata, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_full", btx_full, 0);
    chk("rst_err", tx_err, 0);
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 64; i++) wr(8'(i));
    build(h1, 64);
    exp_len = 78;
    chk("model_size", exp_q.size(), 78);
    chk("model_b0", exp_q[0], 8'h0A);
    chk("model_b12", exp_q[12], 8'h08);
    chk("model_b13", exp_q[13], 8'h00);
    chk("model_b77", exp_q[77], 8'h3F);
    start(h1, 64);
    @(negedge clk);
    chk("lat_wait_tvalid", axis.tx_axis_tvalid, 0);
    chk("lat_busy", tx_busy, 1);
    @(negedge clk);
    chk("lat_first_tvalid", axis.tx_axis_tvalid, 1);
    chk("lat_first_byte", axis.tx_axis_tdata, 8'h0A);
    @(posedge clk); #1;
    tx_start = 1;
    tx_len = 11'd1501;
    @(posedge clk); #1;
    tx_start = 0;
    @(negedge clk);
    chk("busy_start_no_err", tx_err, 0);
    @(posedge clk); #1;
    wait_done();
    for (int i = 0; i < 10; i++) wr(8'hA0 + 8'(i));
    build(h1, 10);
    exp_len = 60;
    chk("model_len10_last_pay", exp_q[23], 8'hA9);
    start(h1, 10);
    wait_done();
    wr(8'hB0); wr(8'hB1); wr(8'hB2);
    build(h2, 0);
    exp_len = 60;
    start(h2, 0);
    wait_done();
    build(h2, 3);
    exp_len = 60;
    start(h2, 3);
    wait_done();
    for (int i = 0; i < 100; i++) wr(8'(i * 7 + 3));
    build(h2, 100);
    exp_len = 114;
    rand_rdy = 1;
    start(h2, 100);
    wait_done();
    rand_rdy = 0;
    axis.tx_axis_tready = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) wr(8'hC0 + 8'(i));
    start(h1, 20);
    repeat (4) @(negedge clk);
    chk("underfill_wait_tvalid", axis.tx_axis_tvalid, 0);
    chk("underfill_busy", tx_busy, 1);
    @(posedge clk); #1;
    for (int i = 5; i < 20; i++) wr(8'hC0 + 8'(i));
    build(h1, 20);
    exp_len = 60;
    @(negedge clk);
    chk("fill_edge_tvalid", axis.tx_axis_tvalid, 0);
    @(negedge clk);
    chk("fill_next_tvalid", axis.tx_axis_tvalid, 1);
    @(posedge clk); #1;
    wait_done();
    tx_start = 1;
    tx_len = 11'd1501;
    @(posedge clk); #1;
    tx_start = 0;
    @(negedge clk);
    chk("err_pulse", tx_err, 1);
    chk("err_busy", tx_busy, 0);
    @(negedge clk);
    chk("err_one_cycle", tx_err, 0);
    chk("err_busy_after", tx_busy, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 2048; i++) wr(8'(i));
    @(negedge clk);
    chk("full_set", btx_full, 1);
    @(posedge clk); #1;
    btx_wr_en = 1;
    tx_data = 8'hEE;
    @(posedge clk); #1;
    btx_wr_en = 0;
    @(negedge clk);
    chk("full_hold", btx_full, 1);
    @(posedge clk); #1;
    build(h1, 1500);
    exp_len = 1514;
    start(h1, 1500);
    wait_done();
    chk("full_clear", btx_full, 0);
    build(h1, 548);
    exp_len = 562;
    start(h1, 548);
    wait_done();
    start(h1, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("dropped_write_absent", axis.tx_axis_tvalid, 0);
    chk("dropped_busy", tx_busy, 1);
    rst = 1;
    #1;
    chk("rst_wait_busy", tx_busy, 0);
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 30; i++) wr(8'h40 + 8'(i));
    build(h1, 30);
    exp_len = 60;
    start(h1, 30);
    n = 0;
    while (nbytes < 20 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("reach_payload", n < 200, 1);
    #2;
    rst = 1;
    #1;
    chk("midrst_tvalid", axis.tx_axis_tvalid, 0);
    chk("midrst_tlast", axis.tx_axis_tlast, 0);
    chk("midrst_busy", tx_busy, 0);
    chk("midrst_full", btx_full, 0);
    exp_q.delete();
    pl.delete();
    in_frame = 0;
    nbytes = 0;
    p_stall = 0;
    @(posedge clk); #1;
    rst = 0;
    start(h1, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("flushed_buffer", axis.tx_axis_tvalid, 0);
    wr(8'h77);
    build(h1, 1);
    exp_len = 60;
    wait_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
